// File: rtl/cpu_ctrl_mc.sv
// rtl/cpu_ctrl_mc.sv - multi-cycle control FSM with memory handshake, timeout and sticky error
// Optional conditional branches are built when CTRL_BRANCH_EN is defined.
module cpu_ctrl_mc #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       mem_ack,
    output logic [1:0] reg_sel,
    output logic [1:0] wb_sel,
    output logic       w_en,
    output logic       en_A,
    output logic       en_B,
    output logic       en_C,
    output logic       en_status,
    output logic       sel_A,
    output logic       sel_B,
    output logic       load_pc,
    output logic       clear_pc,
    output logic       load_ir,
    output logic       load_addr,
    output logic       pc_sel,
    output logic       sel_addr,
    output logic       mem_req,
    output logic       ram_w_en,
    output logic       halted,
    output logic       err
);
    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_WB_IMM, S_GET_A, S_GET_B, S_EXEC, S_WB,
        S_CMP_S, S_ADDR, S_LD_ADDR, S_MEM_RD, S_GET_RD, S_PASS_B, S_MEM_WR,
        S_BRANCH, S_HALT
    } state_t;

    localparam bit            TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [4:0]        ins;
    logic              is_cmp, is_mvx, is_ldr, is_mem, in_wait, timeout;

    // IR is stable after FETCH, so later states decode the live opcode fields
    assign ins     = {opcode, op};
    assign is_cmp  = (ins == 5'b101_01);
    assign is_mvx  = (ins == 5'b110_00) || (ins == 5'b101_11);
    assign is_ldr  = (ins == 5'b011_00);
    assign is_mem  = (opcode == 3'b011) || (opcode == 3'b100);
    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout = TO_EN && (cnt_q == TO_LAST);
    assign err     = err_q;

`ifndef CTRL_BRANCH_EN
    logic unused_branch;
    assign unused_branch = ^{cond, Z, N, V};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        cnt_d     = '0;
        reg_sel   = 2'b11;
        wb_sel    = 2'b00;
        w_en      = 1'b0;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b1;
        load_pc   = 1'b0;
        clear_pc  = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        pc_sel    = 1'b0;
        sel_addr  = 1'b0;
        mem_req   = 1'b0;
        ram_w_en  = 1'b0;
        halted    = 1'b0;

        // an ack in the same cycle as the timeout takes priority
        if (in_wait && !mem_ack) begin
            cnt_d = cnt_q + TO_W'(1);
            if (timeout) begin
                err_d   = 1'b1;
                state_d = S_HALT;
            end
        end

        case (state_q)
            S_RESET: begin
                clear_pc = 1'b1;
                sel_B    = 1'b0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                sel_addr = 1'b1;
                mem_req  = 1'b1;
                if (mem_ack) begin
                    load_ir = 1'b1;
                    load_pc = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                casez (ins)
                    5'b110_10:                               state_d = S_WB_IMM;
                    5'b110_00, 5'b101_11:                    state_d = S_GET_B;
                    5'b101_00, 5'b101_10, 5'b101_01,
                    5'b011_00, 5'b100_00:                    state_d = S_GET_A;
                    5'b111_??:                               state_d = S_HALT;
`ifdef CTRL_BRANCH_EN
                    5'b001_??:                               state_d = S_BRANCH;
`endif
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_WB_IMM: begin
                reg_sel = 2'b10;
                wb_sel  = 2'b10;
                w_en    = 1'b1;
                state_d = S_FETCH;
            end
            S_GET_A: begin
                reg_sel = 2'b10;
                en_A    = 1'b1;
                state_d = is_mem ? S_ADDR : S_GET_B;
            end
            S_GET_B: begin
                reg_sel = 2'b01;
                en_B    = 1'b1;
                state_d = is_cmp ? S_CMP_S : S_EXEC;
            end
            S_EXEC: begin
                en_C    = 1'b1;
                sel_A   = is_mvx;
                sel_B   = 1'b0;
                state_d = S_WB;
            end
            S_WB: begin
                reg_sel = 2'b00;
                wb_sel  = 2'b00;
                w_en    = 1'b1;
                state_d = S_FETCH;
            end
            S_CMP_S: begin
                sel_B     = 1'b0;
                en_status = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                en_C    = 1'b1;
                state_d = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                load_addr = 1'b1;
                state_d   = is_ldr ? S_MEM_RD : S_GET_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    reg_sel = 2'b00;
                    wb_sel  = 2'b11;
                    w_en    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_GET_RD: begin
                reg_sel = 2'b00;
                en_B    = 1'b1;
                state_d = S_PASS_B;
            end
            S_PASS_B: begin
                sel_A   = 1'b1;
                sel_B   = 1'b0;
                en_C    = 1'b1;
                state_d = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                ram_w_en = 1'b1;
                if (mem_ack) state_d = S_FETCH;
            end
            S_BRANCH: begin
`ifdef CTRL_BRANCH_EN
                state_d = S_FETCH;
                case (cond)
                    3'b000: load_pc = 1'b1;
                    3'b001: load_pc = Z;
                    3'b010: load_pc = !Z;
                    3'b011: load_pc = (N != V);
                    3'b100: load_pc = (N != V) || Z;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
                pc_sel = load_pc;
`else
                err_d   = 1'b1;
                state_d = S_HALT;
`endif
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_cpu_ctrl_mc.sv
// tb/tb_cpu_ctrl_mc.sv - instruction-level model and per-cycle output compare for cpu_ctrl_mc
module tb_cpu_ctrl_mc;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = '0, cond = '0;
    logic [1:0] op = '0;
    logic       Z = 1'b0, N = 1'b0, V = 1'b0, mem_ack = 1'b0;
    logic [1:0] reg_sel, wb_sel;
    logic w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, load_pc, clear_pc;
    logic load_ir, load_addr, pc_sel, sel_addr, mem_req, ram_w_en, halted, err;

    always #5 clk = ~clk;

    cpu_ctrl_mc #(.MEM_TIMEOUT(TMO), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .op(op), .cond(cond),
        .Z(Z), .N(N), .V(V), .mem_ack(mem_ack),
        .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B),
        .en_C(en_C), .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B),
        .load_pc(load_pc), .clear_pc(clear_pc), .load_ir(load_ir), .load_addr(load_addr),
        .pc_sel(pc_sel), .sel_addr(sel_addr), .mem_req(mem_req), .ram_w_en(ram_w_en),
        .halted(halted), .err(err)
    );

    typedef struct packed {
        logic [1:0] reg_sel;
        logic [1:0] wb_sel;
        logic w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, load_pc, clear_pc;
        logic load_ir, load_addr, pc_sel, sel_addr, mem_req, ram_w_en, halted, err;
    } out_t;

    typedef struct {
        logic       rst;
        logic       ack;
        logic [7:0] ir;
        logic [2:0] f;
        out_t       e;
        string      tag;
    } rec_t;

    rec_t       q[$];
    logic       m_err = 1'b0, m_halt = 1'b0;
    logic [7:0] cur_ir = '0;
    logic [2:0] cur_f = '0;
    int         total = 0, bad = 0;
    int         rd_req = 0, rd_wen = 0;
    out_t       act;

    assign act = {reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
                  load_pc, clear_pc, load_ir, load_addr, pc_sel, sel_addr, mem_req,
                  ram_w_en, halted, err};

    task automatic chk(string nm, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    function automatic out_t base();
        out_t o = '0;
        o.reg_sel = 2'b11;
        o.sel_B   = 1'b1;
        o.err     = m_err;
        return o;
    endfunction

    task automatic push_r(logic rst, string tag, logic ack, out_t e);
        rec_t r;
        r.rst = rst; r.ack = ack; r.ir = cur_ir; r.f = cur_f; r.e = e; r.tag = tag;
        q.push_back(r);
    endtask

    task automatic push(string tag, logic ack, out_t e);
        push_r(1'b1, tag, ack, e);
    endtask

    task automatic do_reset(int n);
        out_t o = '0;
        o.reg_sel  = 2'b11;
        o.clear_pc = 1'b1;
        m_err  = 1'b0;
        m_halt = 1'b0;
        for (int i = 0; i < n; i++) push_r(1'b0, "RST", 1'b0, o);
        push("RESET", 1'b0, o);
    endtask

    task automatic halt_n(int n);
        out_t o;
        m_halt = 1'b1;
        o = base();
        o.halted = 1'b1;
        for (int i = 0; i < n; i++) push("HALT", i[0], o);
    endtask

    // a wait stage: delay cycles without ack, then the ack cycle, unless the timeout comes first
    task automatic mem_wait(string tag, int delay, out_t w, out_t a, output bit to);
        to = (delay >= TMO);
        for (int i = 0; i < (to ? TMO : delay); i++) push(tag, 1'b0, w);
        if (to) m_err = 1'b1;
        else    push(tag, 1'b1, a);
    endtask

    task automatic run(logic [7:0] ir, logic [2:0] f, int fd, int md, int abort);
        out_t o, w, a;
        bit to;
        logic [4:0] ins;
        logic z, n, v, tk, ill;
        cur_ir = ir; cur_f = f; ins = ir[7:3]; {z, n, v} = f;
        w = base(); w.sel_addr = 1'b1; w.mem_req = 1'b1;
        a = w; a.load_ir = 1'b1; a.load_pc = 1'b1;
        mem_wait("FETCH", fd, w, a, to);
        if (to) begin halt_n(3); return; end
        push("DECODE", 1'b1, base());
        if (ins == 5'b110_10) begin
            o = base(); o.reg_sel = 2'b10; o.wb_sel = 2'b10; o.w_en = 1'b1; push("WB_IMM", 1'b1, o);
        end else if (ins inside {5'b101_00, 5'b101_10, 5'b101_01, 5'b110_00, 5'b101_11}) begin
            if (!(ins inside {5'b110_00, 5'b101_11})) begin
                o = base(); o.reg_sel = 2'b10; o.en_A = 1'b1; push("GET_A", 1'b1, o);
            end
            o = base(); o.reg_sel = 2'b01; o.en_B = 1'b1; push("GET_B", 1'b1, o);
            if (ins == 5'b101_01) begin
                o = base(); o.sel_B = 1'b0; o.en_status = 1'b1; push("CMP_S", 1'b1, o);
            end else begin
                o = base(); o.en_C = 1'b1; o.sel_B = 1'b0;
                o.sel_A = (ins inside {5'b110_00, 5'b101_11}); push("EXEC", 1'b1, o);
                o = base(); o.reg_sel = 2'b00; o.wb_sel = 2'b00; o.w_en = 1'b1; push("WB", 1'b1, o);
            end
        end else if (ins inside {5'b011_00, 5'b100_00}) begin
            o = base(); o.reg_sel = 2'b10; o.en_A = 1'b1; push("GET_A", 1'b1, o);
            o = base(); o.en_C = 1'b1; push("ADDR", 1'b1, o);
            o = base(); o.load_addr = 1'b1; push("LD_ADDR", 1'b1, o);
            if (ins == 5'b011_00) begin
                w = base(); w.mem_req = 1'b1;
                a = w; a.reg_sel = 2'b00; a.wb_sel = 2'b11; a.w_en = 1'b1;
                mem_wait("MEM_RD", md, w, a, to);
            end else begin
                o = base(); o.reg_sel = 2'b00; o.en_B = 1'b1; push("GET_RD", 1'b1, o);
                o = base(); o.sel_A = 1'b1; o.sel_B = 1'b0; o.en_C = 1'b1; push("PASS_B", 1'b1, o);
                w = base(); w.mem_req = 1'b1; w.ram_w_en = 1'b1;
                if (abort >= 0) begin
                    for (int i = 0; i < abort; i++) push("MEM_WR", 1'b0, w);
                    return;
                end
                mem_wait("MEM_WR", md, w, w, to);
            end
            if (to) halt_n(3);
        end else if (ir[7:5] == 3'b111) begin
            halt_n(3);
        end else if (ir[7:5] == 3'b001) begin
`ifdef CTRL_BRANCH_EN
            ill = 1'b0;
            case (ir[2:0])
                3'd0: tk = 1'b1;
                3'd1: tk = z;
                3'd2: tk = !z;
                3'd3: tk = (n != v);
                3'd4: tk = (n != v) | z;
                default: begin tk = 1'b0; ill = 1'b1; end
            endcase
            o = base(); o.load_pc = tk; o.pc_sel = tk; push("BRANCH", 1'b1, o);
            if (ill) begin m_err = 1'b1; halt_n(3); end
`else
            tk = 1'b0; ill = 1'b1;
            m_err = tk | ill;
            halt_n(3);
`endif
        end else begin
            m_err = 1'b1;
            halt_n(3);
        end
    endtask

    task automatic step(logic [7:0] ir, logic [2:0] f, int fd, int md);
        run(ir, f, fd, md, -1);
        if (m_halt) do_reset(1);
    endtask

    initial begin
        int n0;
        do_reset(2);
        n0 = q.size(); run(8'b110_10_000, 3'b000, 0, 0, -1); chk("movi_len", q.size() - n0, 3);
        n0 = q.size(); run(8'b101_00_000, 3'b000, 0, 0, -1); chk("add_len", q.size() - n0, 6);
        n0 = q.size(); run(8'b101_01_000, 3'b000, 0, 0, -1); chk("cmp_len", q.size() - n0, 5);
        step(8'b101_10_000, 3'b000, 0, 0);
        step(8'b110_00_000, 3'b000, 0, 0);
        step(8'b101_11_000, 3'b000, 1, 0);
        n0 = q.size(); run(8'b011_00_000, 3'b000, 0, 3, -1); chk("ldr_len", q.size() - n0, 9);
        step(8'b100_00_000, 3'b000, 2, 1);
        run(8'b100_00_000, 3'b000, 0, 0, 2);
        do_reset(1);
        step(8'b001_00_001, 3'b100, 0, 0);
        step(8'b001_00_001, 3'b000, 0, 0);
        step(8'b001_00_010, 3'b000, 0, 0);
        step(8'b001_00_011, 3'b010, 0, 0);
        step(8'b001_00_100, 3'b000, 0, 0);
        step(8'b001_00_000, 3'b000, 0, 0);
        step(8'b001_00_101, 3'b000, 0, 0);
        step(8'b110_10_000, 3'b000, 10, 0);
        step(8'b010_00_000, 3'b000, 0, 0);
        step(8'b110_01_000, 3'b000, 0, 0);
        step(8'b111_00_000, 3'b000, 0, 0);
        step(8'b110_10_000, 3'b000, 3, 0);

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            rst_n   = q[i].rst;
            mem_ack = q[i].ack;
            {opcode, op, cond} = q[i].ir;
            {Z, N, V} = q[i].f;
            @(negedge clk);
            total++;
            if (act !== q[i].e) begin
                bad++;
                $display("FAIL cyc%0d %s: got %h want %h", i, q[i].tag, act, q[i].e);
            end
            if (q[i].tag == "MEM_RD") begin
                rd_req += int'(mem_req);
                rd_wen += int'(w_en);
            end
        end
        chk("ldr_req_cycles", rd_req, 4);
        chk("ldr_wen_cycles", rd_wen, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
